fmac_booth_mult_iter: RTL

Iterative radix-4 Booth multiplier stage that sits directly upstream of the FMAC alignment stage. It computes the significand product Mant_b × Mant_c in carry-save form (Pp_sum/Pp_carry). It forwards the addend and exponent/sign fields alongside the product, so the aligner receives one consistent operand set per handshake. It retires one Booth digit per cycle and uses a valid/ready handshake on both sides.

---
 rtl/fmac_booth_mult_iter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fmac_booth_mult_iter.sv
// rtl/fmac_booth_mult_iter.sv - iterative radix-4 Booth significand multiplier feeding the FMAC aligner
//
// Purpose: computes Mant_b x Mant_c in carry-save form, retiring one radix-4
// Booth digit per cycle through a 3:2 compressor. Addend, exponents and signs
// are captured with the operands and presented together with the product.
//
// Ports:
//   Clk_CI, Rst_RBI           clock (rising edge), async active-low reset
//   Flush_SI                  synchronous abort, overrides every other action
//   Valid_SI / Ready_SO       operand-side handshake
//   Exp_*_DI, Mant_*_DI,
//   Sign_*_DI                 operand set (significands include hidden bit)
//   Valid_SO / Ready_SI       result-side handshake toward the aligner
//   Exp_*_DO, Mant_a_DO,
//   Sign_*_DO                 captured pass-through fields
//   Pp_sum_DO / Pp_carry_DO   carry-save product, sum+carry mod 2^49 = Mant_b*Mant_c

module fmac_booth_mult_iter #(
   parameter int C_FMAC_MANT = 23,
   parameter int C_FMAC_EXP  = 8
) (
   input  logic                     Clk_CI,
   input  logic                     Rst_RBI,
   input  logic                     Flush_SI,
   input  logic                     Valid_SI,
   output logic                     Ready_SO,
   input  logic [C_FMAC_EXP-1:0]    Exp_a_DI,
   input  logic [C_FMAC_EXP-1:0]    Exp_b_DI,
   input  logic [C_FMAC_EXP-1:0]    Exp_c_DI,
   input  logic [C_FMAC_MANT:0]     Mant_a_DI,
   input  logic [C_FMAC_MANT:0]     Mant_b_DI,
   input  logic [C_FMAC_MANT:0]     Mant_c_DI,
   input  logic                     Sign_a_DI,
   input  logic                     Sign_b_DI,
   input  logic                     Sign_c_DI,
   output logic                     Valid_SO,
   input  logic                     Ready_SI,
   output logic [C_FMAC_EXP-1:0]    Exp_a_DO,
   output logic [C_FMAC_EXP-1:0]    Exp_b_DO,
   output logic [C_FMAC_EXP-1:0]    Exp_c_DO,
   output logic [C_FMAC_MANT:0]     Mant_a_DO,
   output logic                     Sign_a_DO,
   output logic                     Sign_b_DO,
   output logic                     Sign_c_DO,
   output logic [2*C_FMAC_MANT+2:0] Pp_sum_DO,
   output logic [2*C_FMAC_MANT+2:0] Pp_carry_DO
);

   localparam int C_SIG_W  = C_FMAC_MANT + 1;
   localparam int C_PP_W   = 2*C_FMAC_MANT + 3;
   localparam int C_DIGITS = (C_SIG_W + 2) / 2;
   localparam int C_X_W    = 2*C_DIGITS + 1;
   localparam int C_CNT_W  = $clog2(C_DIGITS);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t               r_state;
   logic [C_CNT_W-1:0]   r_cnt;
   logic                 r_valid;
   logic [C_PP_W-1:0]    r_sum;
   logic [C_PP_W-1:0]    r_carry;
   logic [C_SIG_W-1:0]   r_mant_b;
   logic [C_SIG_W-1:0]   r_mant_c;
   logic [C_FMAC_EXP-1:0] r_exp_a, r_exp_b, r_exp_c;
   logic [C_SIG_W-1:0]   r_mant_a;
   logic                 r_sign_a, r_sign_b, r_sign_c;

   logic                 w_accept;
   logic [C_X_W-1:0]     w_x;
   logic [C_X_W-1:0]     w_x_sh;
   logic [2:0]           w_digit;
   logic [C_PP_W-1:0]    w_b_ext;
   logic [C_PP_W-1:0]    w_mag;
   logic                 w_neg;
   logic [C_PP_W-1:0]    w_mag_sh;
   logic [C_PP_W-1:0]    w_pp;
   logic [C_PP_W-1:0]    w_maj;
   logic [C_PP_W-1:0]    w_sum_nxt;
   logic [C_PP_W-1:0]    w_carry_nxt;

   // Ready depends only on state and the downstream ready so that a result
   // can be consumed and the next operand set accepted in the same cycle.
   assign Ready_SO = (r_state == S_IDLE) || ((r_state == S_DONE) && Ready_SI);
   assign w_accept = Valid_SI && Ready_SO;

   // Two zero guard bits on top keep the last digit non-negative for an
   // unsigned multiplier; the implicit zero below bit 0 starts the recoding.
   assign w_x     = {2'b00, r_mant_c, 1'b0};
   assign w_x_sh  = w_x >> {r_cnt, 1'b0};
   assign w_digit = w_x_sh[2:0];
   assign w_b_ext = {{(C_PP_W-C_SIG_W){1'b0}}, r_mant_b};

   always_comb begin
      w_mag = '0;
      w_neg = 1'b0;
      case (w_digit)
         3'b001, 3'b010: w_mag = w_b_ext;
         3'b011:         w_mag = w_b_ext << 1;
         3'b100: begin
            w_mag = w_b_ext << 1;
            w_neg = 1'b1;
         end
         3'b101, 3'b110: begin
            w_mag = w_b_ext;
            w_neg = 1'b1;
         end
         default: w_mag = '0;
      endcase
   end

   // Negative digits enter as the one's complement; the missing +1 rides in
   // the free LSB of the shifted carry vector.
   assign w_mag_sh    = w_mag << {r_cnt, 1'b0};
   assign w_pp        = w_neg ? ~w_mag_sh : w_mag_sh;
   assign w_sum_nxt   = r_sum ^ r_carry ^ w_pp;
   assign w_maj       = (r_sum & r_carry) | (r_sum & w_pp) | (r_carry & w_pp);
   assign w_carry_nxt = {w_maj[C_PP_W-2:0], w_neg};

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_sum    <= '0;
         r_carry  <= '0;
         r_mant_b <= '0;
         r_mant_c <= '0;
         r_exp_a  <= '0;
         r_exp_b  <= '0;
         r_exp_c  <= '0;
         r_mant_a <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_sign_c <= 1'b0;
      end else if (Flush_SI) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_carry <= '0;
      end else if (w_accept) begin
         r_state  <= S_BUSY;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_sum    <= '0;
         r_carry  <= '0;
         r_mant_b <= Mant_b_DI;
         r_mant_c <= Mant_c_DI;
         r_exp_a  <= Exp_a_DI;
         r_exp_b  <= Exp_b_DI;
         r_exp_c  <= Exp_c_DI;
         r_mant_a <= Mant_a_DI;
         r_sign_a <= Sign_a_DI;
         r_sign_b <= Sign_b_DI;
         r_sign_c <= Sign_c_DI;
      end else begin
         case (r_state)
            S_IDLE: r_valid <= 1'b0;
            S_BUSY: begin
               r_sum   <= w_sum_nxt;
               r_carry <= w_carry_nxt;
               if (r_cnt == C_CNT_W'(C_DIGITS-1)) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_CNT_W'(1);
               end
            end
            S_DONE: begin
               if (Ready_SI) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign Valid_SO    = r_valid;
   assign Exp_a_DO    = r_exp_a;
   assign Exp_b_DO    = r_exp_b;
   assign Exp_c_DO    = r_exp_c;
   assign Mant_a_DO   = r_mant_a;
   assign Sign_a_DO   = r_sign_a;
   assign Sign_b_DO   = r_sign_b;
   assign Sign_c_DO   = r_sign_c;
   assign Pp_sum_DO   = r_sum;
   assign Pp_carry_DO = r_carry;

endmodule
